// File: rtl/pixel_stream_framer.sv
// Frames a raster-order RGB pixel stream: tags each accepted pixel with row/col
// and sof/eol/eof, and produces per-channel sums and a count for every completed frame.
module pixel_stream_framer #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int PIXEL_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    flush,
  input  logic                    valid,
  input  logic [PIXEL_DEPTH-1:0]  VGA_R,
  input  logic [PIXEL_DEPTH-1:0]  VGA_G,
  input  logic [PIXEL_DEPTH-1:0]  VGA_B,
  output logic                    valid_o,
  output logic [PIXEL_DEPTH-1:0]  R_o,
  output logic [PIXEL_DEPTH-1:0]  G_o,
  output logic [PIXEL_DEPTH-1:0]  B_o,
  output logic [12:0]             row,
  output logic [12:0]             col,
  output logic                    sof,
  output logic                    eol,
  output logic                    eof,
  output logic                    frame_done,
  output logic [PIXEL_DEPTH+18:0] sum_R,
  output logic [PIXEL_DEPTH+18:0] sum_G,
  output logic [PIXEL_DEPTH+18:0] sum_B,
  output logic [15:0]             frame_count
);

  localparam int SUM_W = PIXEL_DEPTH + 19;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state;
  logic [12:0]      row_p0;
  logic [12:0]      col_p0;
  logic [SUM_W-1:0] acc_r_p0;
  logic [SUM_W-1:0] acc_g_p0;
  logic [SUM_W-1:0] acc_b_p0;
  logic             accept_p0;
  logic             abort_p0;
  logic             last_col_p0;
  logic             last_pix_p0;

  function automatic logic [SUM_W-1:0] zext(input logic [PIXEL_DEPTH-1:0] v);
    return {{(SUM_W-PIXEL_DEPTH){1'b0}}, v};
  endfunction

  // Flush only matters while a frame is open; in IDLE it is ignored entirely.
  always_comb begin
    abort_p0    = (state == ACTIVE) && flush;
    accept_p0   = valid && !abort_p0 && ((state == ACTIVE) || en);
    last_col_p0 = (col_p0 == 13'(WIDTH - 1));
    last_pix_p0 = last_col_p0 && (row_p0 == 13'(HEIGHT - 1));
  end

  // ---- stage p0 -> p1: position tracking, accumulation, registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      row_p0      <= '0;
      col_p0      <= '0;
      acc_r_p0    <= '0;
      acc_g_p0    <= '0;
      acc_b_p0    <= '0;
      valid_o     <= 1'b0;
      R_o         <= '0;
      G_o         <= '0;
      B_o         <= '0;
      row         <= '0;
      col         <= '0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      eof         <= 1'b0;
      frame_done  <= 1'b0;
      sum_R       <= '0;
      sum_G       <= '0;
      sum_B       <= '0;
      frame_count <= '0;
    end else begin
      valid_o    <= accept_p0;
      sof        <= 1'b0;
      eol        <= 1'b0;
      eof        <= 1'b0;
      frame_done <= 1'b0;
      if (abort_p0) begin
        state    <= IDLE;
        row_p0   <= '0;
        col_p0   <= '0;
        acc_r_p0 <= '0;
        acc_g_p0 <= '0;
        acc_b_p0 <= '0;
      end else if (accept_p0) begin
        R_o <= VGA_R;
        G_o <= VGA_G;
        B_o <= VGA_B;
        row <= row_p0;
        col <= col_p0;
        sof <= (row_p0 == '0) && (col_p0 == '0);
        eol <= last_col_p0;
        eof <= last_pix_p0;
        if (last_pix_p0) begin
          // Totals include the final pixel; accumulators restart for the next frame.
          sum_R       <= acc_r_p0 + zext(VGA_R);
          sum_G       <= acc_g_p0 + zext(VGA_G);
          sum_B       <= acc_b_p0 + zext(VGA_B);
          acc_r_p0    <= '0;
          acc_g_p0    <= '0;
          acc_b_p0    <= '0;
          frame_done  <= 1'b1;
          frame_count <= frame_count + 16'd1;
          row_p0      <= '0;
          col_p0      <= '0;
          state       <= en ? ACTIVE : IDLE;
        end else begin
          acc_r_p0 <= acc_r_p0 + zext(VGA_R);
          acc_g_p0 <= acc_g_p0 + zext(VGA_G);
          acc_b_p0 <= acc_b_p0 + zext(VGA_B);
          state    <= ACTIVE;
          if (last_col_p0) begin
            col_p0 <= '0;
            row_p0 <= row_p0 + 13'd1;
          end else begin
            col_p0 <= col_p0 + 13'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_framer.sv
// Scoreboard bench for pixel_stream_framer on a 4x3 raster: a behavioural model
// predicts every output cycle, expectations are queued and compared half a cycle later.
module tb_pixel_stream_framer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int PD = 8;
  localparam int SW = PD + 19;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic          flush;
  logic          valid;
  logic [PD-1:0] VGA_R, VGA_G, VGA_B;
  logic          valid_o;
  logic [PD-1:0] R_o, G_o, B_o;
  logic [12:0]   row, col;
  logic          sof, eol, eof, frame_done;
  logic [SW-1:0] sum_R, sum_G, sum_B;
  logic [15:0]   frame_count;

  pixel_stream_framer #(.WIDTH(W), .HEIGHT(H), .PIXEL_DEPTH(PD)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .flush(flush), .valid(valid),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .valid_o(valid_o), .R_o(R_o), .G_o(G_o), .B_o(B_o),
    .row(row), .col(col), .sof(sof), .eol(eol), .eof(eof),
    .frame_done(frame_done), .sum_R(sum_R), .sum_G(sum_G), .sum_B(sum_B),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [PD-1:0] r, g, b;
    logic [12:0]   row, col;
    logic          sof, eol, eof, fd;
    logic [SW-1:0] sr, sg, sb;
    logic [15:0]   fc;
  } exp_t;

  exp_t q[$];
  exp_t m_out;
  exp_t got_e;
  bit   m_active;
  int   m_pix;
  logic [SW-1:0] m_acc_r, m_acc_g, m_acc_b;
  bit   prev_fd;

  int n_cmp = 0;
  int n_err = 0;

  task automatic model_reset();
    q.delete();
    m_active = 1'b0;
    m_pix    = 0;
    m_acc_r  = '0;
    m_acc_g  = '0;
    m_acc_b  = '0;
    m_out    = '{v:1'b0, r:'0, g:'0, b:'0, row:'0, col:'0, sof:1'b0, eol:1'b0,
                 eof:1'b0, fd:1'b0, sr:'0, sg:'0, sb:'0, fc:'0};
    prev_fd  = 1'b0;
  endtask

  // One clock cycle: apply inputs, predict, then compare the DUT half a cycle after the edge.
  task automatic drive(input logic v, input logic e, input logic f,
                       input logic [PD-1:0] r, input logic [PD-1:0] g, input logic [PD-1:0] b);
    exp_t x;
    bit   acc;
    valid = v; en = e; flush = f; VGA_R = r; VGA_G = g; VGA_B = b;
    acc = v && (m_active ? !f : e);
    x = m_out;
    x.v = acc; x.sof = 1'b0; x.eol = 1'b0; x.eof = 1'b0; x.fd = 1'b0;
    if (m_active && f) begin
      m_active = 1'b0; m_pix = 0; m_acc_r = '0; m_acc_g = '0; m_acc_b = '0;
    end else if (acc) begin
      x.r = r; x.g = g; x.b = b;
      x.row = 13'(m_pix / W);
      x.col = 13'(m_pix % W);
      x.sof = (m_pix == 0);
      x.eol = ((m_pix % W) == W - 1);
      x.eof = (m_pix == W * H - 1);
      m_acc_r += SW'(r); m_acc_g += SW'(g); m_acc_b += SW'(b);
      if (x.eof) begin
        x.sr = m_acc_r; x.sg = m_acc_g; x.sb = m_acc_b;
        x.fd = 1'b1;
        x.fc = m_out.fc + 16'd1;
        m_acc_r = '0; m_acc_g = '0; m_acc_b = '0;
        m_pix = 0;
        m_active = e;
      end else begin
        m_pix++;
        m_active = 1'b1;
      end
    end
    m_out = x;
    @(posedge clk);
    q.push_back(x);
    @(negedge clk);
    if (q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_empty: got no expectation, required one queued");
    end else begin
      got_e = q.pop_front();
      n_cmp++;
      if ({valid_o, R_o, G_o, B_o} !== {got_e.v, got_e.r, got_e.g, got_e.b}) begin
        n_err++;
        $display("FAIL pixel: got v=%b rgb=%h/%h/%h required v=%b rgb=%h/%h/%h",
                 valid_o, R_o, G_o, B_o, got_e.v, got_e.r, got_e.g, got_e.b);
      end
      n_cmp++;
      if ({row, col} !== {got_e.row, got_e.col}) begin
        n_err++;
        $display("FAIL position: got row=%0d col=%0d required row=%0d col=%0d",
                 row, col, got_e.row, got_e.col);
      end
      n_cmp++;
      if ({sof, eol, eof, frame_done} !== {got_e.sof, got_e.eol, got_e.eof, got_e.fd}) begin
        n_err++;
        $display("FAIL flags: got sof/eol/eof/fd=%b%b%b%b required %b%b%b%b",
                 sof, eol, eof, frame_done, got_e.sof, got_e.eol, got_e.eof, got_e.fd);
      end
      n_cmp++;
      if ({sum_R, sum_G, sum_B, frame_count} !== {got_e.sr, got_e.sg, got_e.sb, got_e.fc}) begin
        n_err++;
        $display("FAIL stats: got sums=%0d/%0d/%0d count=%0d required sums=%0d/%0d/%0d count=%0d",
                 sum_R, sum_G, sum_B, frame_count, got_e.sr, got_e.sg, got_e.sb, got_e.fc);
      end
      n_cmp++;
      if (frame_done && prev_fd) begin
        n_err++;
        $display("FAIL frame_done_back_to_back: got 1 on consecutive cycles required isolated pulse");
      end
      prev_fd = frame_done;
    end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({valid_o, R_o, G_o, B_o, row, col, sof, eol, eof, frame_done,
         sum_R, sum_G, sum_B, frame_count} !== '0) begin
      n_err++;
      $display("FAIL %s: got v=%b rgb=%h/%h/%h row=%0d col=%0d flags=%b%b%b%b sums=%0d/%0d/%0d cnt=%0d required all 0",
               name, valid_o, R_o, G_o, B_o, row, col, sof, eol, eof, frame_done,
               sum_R, sum_G, sum_B, frame_count);
    end
  endtask

  task automatic check_stats(input string name, input int sr, input int sg, input int sb, input int fc);
    n_cmp++;
    if ({sum_R, sum_G, sum_B, frame_count} !== {SW'(sr), SW'(sg), SW'(sb), 16'(fc)}) begin
      n_err++;
      $display("FAIL %s: got sums=%0d/%0d/%0d count=%0d required %0d/%0d/%0d/%0d",
               name, sum_R, sum_G, sum_B, frame_count, sr, sg, sb, fc);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; flush = 1'b0; valid = 1'b0;
    VGA_R = '0; VGA_G = '0; VGA_B = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h55, 8'h66, 8'h77);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_continuous();
    for (int i = 0; i < W * H; i++) drive(1'b1, 1'b1, 1'b0, 8'(i), 8'd1, 8'd0);
    check_stats("continuous_sums", 66, 12, 0, 1);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_gapped();
    for (int i = 0; i < W * H; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'(i), 8'd1, 8'd0);
      drive(1'b0, 1'b1, 1'b0, 8'hEE, 8'hEE, 8'hEE);
    end
    check_stats("gapped_sums", 66, 12, 0, 2);
  endtask

  task automatic test_en_drop();
    for (int i = 0; i < W * H + 4; i++)
      drive(1'b1, (i < 5), 1'b0, 8'(i + 20), 8'd2, 8'd7);
    check_stats("en_drop_sums", 306, 24, 84, 3);
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL en_drop_ignored: got valid_o=%b required 0", valid_o);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 8'd200, 8'd200, 8'd200);
    drive(1'b1, 1'b1, 1'b1, 8'd99, 8'd99, 8'd99);
    check_stats("flush_keeps_stats", 306, 24, 84, 3);
    for (int i = 0; i < W * H; i++) drive(1'b1, 1'b1, 1'b0, 8'd10, 8'd2, 8'd3);
    check_stats("flush_next_frame", 120, 24, 36, 4);
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0, 8'd50, 8'd60, 8'd70);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < W * H; i++) drive(1'b1, 1'b1, 1'b0, 8'(i), 8'd1, 8'd0);
    check_stats("after_reset_frame", 66, 12, 0, 1);
  endtask

  task automatic test_back_to_back();
    int sr, sg, sb;
    logic [PD-1:0] r, g, b;
    for (int f = 0; f < 2; f++) begin
      sr = 0; sg = 0; sb = 0;
      for (int i = 0; i < W * H; i++) begin
        r = 8'($urandom_range(0, 255));
        g = 8'($urandom_range(0, 255));
        b = 8'(255);
        sr += r; sg += g; sb += b;
        drive(1'b1, 1'b1, 1'b0, r, g, b);
      end
      check_stats("back_to_back_frame", sr, sg, sb, 2 + f);
    end
  endtask

  task automatic test_idle_flush();
    drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 8'h11, 8'h22, 8'h33);
    drive(1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 8'h33);
    n_cmp++;
    if (valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ignores_pixels: got valid_o=%b required 0", valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gapped();
    test_en_drop();
    test_flush();
    test_reset_mid_frame();
    test_back_to_back();
    test_idle_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_stream_framer.md
PIXEL_STREAM_FRAMER -- requirements
Module: pixel_stream_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 640, active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480, active lines per frame.
REQ-003 SHALL have parameter PIXEL_DEPTH, default 8, bits per colour channel.
REQ-004 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, frame-granular capture enable.
REQ-007 SHALL have port flush, input, 1, synchronous abort of the current frame.
REQ-008 SHALL have port valid, input, 1, qualifies VGA_R/G/B this cycle.
REQ-009 SHALL have ports VGA_R, VGA_G, VGA_B, input, PIXEL_DEPTH each, raster-order pixel data.
REQ-010 SHALL have port valid_o, output, 1, registered pixel strobe.
REQ-011 SHALL have ports R_o, G_o, B_o, output, PIXEL_DEPTH each, registered pixel data.
REQ-012 SHALL have ports row, col, output, 13 each, position of the pixel on valid_o.
REQ-013 SHALL have ports sof, eol, eof, output, 1 each, first pixel of frame / last of line / last of frame, qualified by valid_o.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse on completed frame.
REQ-015 SHALL have ports sum_R, sum_G, sum_B, output, PIXEL_DEPTH+19 each, per-channel sum of last completed frame.
REQ-016 SHALL have port frame_count, output, 16, completed frames, wraps 0xFFFF->0.

Function
REQ-017 SHALL implement states IDLE and ACTIVE.
REQ-018 IDLE: pixels ignored unless en=1; en=1 and valid=1 accepts pixel as (row 0, col 0) and moves to ACTIVE.
REQ-019 ACTIVE: every valid=1 accepts one pixel; valid=0 cycles hold all position state (gaps of any length allowed).
REQ-020 Accepted pixel SHALL appear on valid_o/R_o/G_o/B_o/row/col exactly 1 cycle later; valid_o=0 otherwise, data outputs hold.
REQ-021 col SHALL increment per accepted pixel, wrap WIDTH-1->0 with row+1; row SHALL wrap HEIGHT-1->0.
REQ-022 sof=1 for (0,0); eol=1 for col=WIDTH-1; eof=1 for (HEIGHT-1,WIDTH-1); all 0 when valid_o=0.
REQ-023 Accumulators SHALL add each accepted pixel channel zero-extended; no overflow possible at max parameters.
REQ-024 On the eof cycle: sum_* SHALL load the final totals (including last pixel), frame_done=1, frame_count+1, accumulators restart from 0.
REQ-025 en=0 mid-frame SHALL NOT abort; current frame completes, then state returns to IDLE; en=1 at eof keeps ACTIVE with next pixel as (0,0).
REQ-026 flush=1: next state IDLE, position and accumulators cleared, no frame_done, sum_* and frame_count unchanged; a pixel presented with flush is dropped (flush wins).
REQ-027 flush in IDLE SHALL be a no-op.
REQ-028 frame_done SHALL never be asserted on two consecutive cycles.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, valid_o=0, R_o/G_o/B_o=0, row=col=0, sof=eol=eof=0, frame_done=0, sum_*=0, frame_count=0, accumulators=0.
REQ-030 Reset mid-frame SHALL discard the partial frame; first accepted pixel after release is (0,0).
REQ-031 Release of reset SHALL take effect on the first rising clk edge with reset_n=1.

Verification (WIDTH=4, HEIGHT=3 unless stated)
REQ-032 Continuous 12 valid pixels, R=index 0..11, G=1, B=0, en=1 -> valid_o 1 cycle delayed, eol at cols 3, eof on 12th, frame_done once, sum_R=66, sum_G=12, sum_B=0, frame_count=1.
REQ-033 Same frame with valid toggled 1/0 every cycle -> identical row/col/flag sequence and sums, frame_done 1 cycle after last accepted pixel.
REQ-034 en dropped after pixel 5, 12 pixels sent then 4 more -> frame completes (frame_count=1), further 4 ignored, valid_o=0 for them.
REQ-035 flush asserted with pixel 7 valid -> pixel 7 not output, no frame_done, next pixel reported (0,0), sums of the following full frame exclude pre-flush data.
REQ-036 reset_n pulsed low mid-frame after 6 pixels -> all outputs 0 asynchronously, next frame sums correct, frame_count=1 after it.
REQ-037 Default parameters, 2 frames of 307200 pixels all 0xFF -> sum_R=sum_G=sum_B=78336000 each frame, frame_count=2, row wraps 479->0.
